controle_multiciclo: RTL and testbench
======================================

CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

Interface
REQ-001 The block SHALL have no parameters; all encodings are fixed constants in the shared package.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  6  instr[31:26] from the instruction register.
REQ-005 funct  input  6  instr[5:0] from the instruction register.
REQ-006 zero  input  1  ULA zero flag from the current cycle.
REQ-007 ulaOp  output  3  ULA operation: AND 000, OR 001, ADD 010, SUB 110, SLT 111.
REQ-008 ula_src_a  output  1  0 = PC, 1 = register A.
REQ-009 ula_src_b  output  2  00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-010 pc_src  output  2  00 = ULA result, 01 = ULAOut register, 10 = jump target.
REQ-011 pc_en, ir_write, mem_write, reg_write  output  1 each  write strobes.
REQ-012 iord, reg_dst, mem_to_reg  output  1 each  mux selects.
REQ-013 estado  output  4  current state code, for debug and bench.

Function
REQ-014 The block SHALL be a Moore FSM, one state register with codes FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
REQ-015 Transitions:
- FETCH->DECODE.
- DECODE by opcode: lw 100011/sw 101011 -> MEMADR; R-type 000000 -> EXEC; beq 000100 -> BRANCH; addi 001000 -> ADDIEX; j 000010 -> JUMP; any other opcode -> FETCH.
- MEMADR -> MEMRD if lw, MEMWR if sw.
- MEMRD->MEMWB; EXEC->ALUWB; ADDIEX->ADDIWB.
- MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH.
- Codes 12-15 -> FETCH.
REQ-016 FETCH SHALL drive iord=0, ula_src_a=0, ula_src_b=01, ulaOp=ADD, pc_src=00, ir_write=1, pc_en=1.
REQ-017 DECODE SHALL drive ula_src_a=0, ula_src_b=11, ulaOp=ADD (branch target precompute).
REQ-018 MEMADR and ADDIEX SHALL drive ula_src_a=1, ula_src_b=10, ulaOp=ADD.
REQ-019 MEMRD: iord=1. MEMWR: iord=1, mem_write=1. MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1.
REQ-020 EXEC SHALL drive ula_src_a=1, ula_src_b=00, ulaOp decoded from funct:
- 100000 -> ADD; 100010 -> SUB; 100100 -> AND; 100101 -> OR; 101010 -> SLT.
- Any other funct -> ADD.
REQ-021 ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1.
REQ-022 BRANCH SHALL drive ula_src_a=1, ula_src_b=00, ulaOp=SUB, pc_src=01, and pc_en=zero combinationally, so the PC is written in the same cycle only when zero=1.
REQ-023 JUMP: pc_src=10, pc_en=1.
REQ-024 In every state, each output not listed for that state SHALL be 0, or 000 for ulaOp.
REQ-025 Instruction latency SHALL be fixed:
- lw 5 cycles; sw, R-type, addi 4 cycles; beq and j 3 cycles.
- Unknown opcode 2 cycles with no write strobe after FETCH.
REQ-026 opcode and funct SHALL be sampled only in DECODE, MEMADR and EXEC; changes in other states SHALL have no effect.

Reset
REQ-027 rst=0 SHALL force estado=FETCH immediately, without waiting for a clock edge.
REQ-028 While rst=0, pc_en, ir_write, mem_write and reg_write SHALL be 0; all other outputs SHALL hold their FETCH values.
REQ-029 Reset asserted in any state, mid-instruction, SHALL abort that instruction; the first posedge after rst rises SHALL leave FETCH with FETCH strobes active.

Structure
REQ-030 The package controle_pkg SHALL hold:
- the state enum (4 bits);
- the opcode and funct constants;
- the ulaOp encodings;
- the 2-bit internal ula_tipo (00 add, 01 sub, 10 funct).
REQ-031 One combinational sub-module, ula_controle, SHALL map ula_tipo and funct to ulaOp; the FSM instantiates it once.

Verification
REQ-032 Reset, then R-type add (opcode 000000, funct 100000) -> estado 0,1,6,7,0; ulaOp=010 in EXEC; reg_write=1, reg_dst=1 only in ALUWB.
REQ-033 lw (100011) -> estado 0,1,2,3,4,0; iord=1 in MEMRD; mem_to_reg=1 and reg_write=1 in MEMWB.
REQ-034 beq (000100), zero=1 then zero=0 -> pc_en=1 and pc_src=01 in BRANCH for the first instruction; pc_en=0 in BRANCH for the second; ulaOp=110 in both.
REQ-035 Each funct 100010/100100/100101/101010/111111 in EXEC -> ulaOp 110/000/001/111/010.
REQ-036 rst driven low between clock edges while in MEMWR -> estado=0 and mem_write=0 before the next posedge; opcode 111111 in DECODE -> FETCH next cycle with no strobe.

Source files
------------

// File: rtl/controle_pkg.sv
// Shared encodings for the multicycle control unit: state codes, opcode and
// funct constants, ULA operation codes and the internal ULA operation class.
package controle_pkg;

    // Controller state; the numeric codes are visible on the estado output.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } estado_t;

    // Opcodes, instr[31:26].
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes, instr[5:0].
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ULA operation codes.
    localparam logic [2:0] ULA_AND = 3'b000;
    localparam logic [2:0] ULA_OR  = 3'b001;
    localparam logic [2:0] ULA_ADD = 3'b010;
    localparam logic [2:0] ULA_SUB = 3'b110;
    localparam logic [2:0] ULA_SLT = 3'b111;

    // Operation class chosen by the FSM; FUNCT defers to the funct field.
    typedef enum logic [1:0] {
        TIPO_ADD   = 2'b00,
        TIPO_SUB   = 2'b01,
        TIPO_FUNCT = 2'b10
    } ula_tipo_t;

    // lw and sw share the address-calculation path.
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/ula_controle.sv
// ULA control decoder: maps the FSM's operation class and the funct field
// to a ULA operation code. Purely combinational.
module ula_controle
    import controle_pkg::*;
(
    input  logic [1:0] ula_tipo,
    input  logic [5:0] funct,
    output logic [2:0] ula_op
);

    // Class ADD/SUB are fixed; FUNCT decodes R-type, unknown funct falls back to ADD.
    always_comb begin
        ula_op = ULA_ADD;
        case (ula_tipo)
            TIPO_ADD: ula_op = ULA_ADD;
            TIPO_SUB: ula_op = ULA_SUB;
            TIPO_FUNCT: begin
                case (funct)
                    FUNCT_ADD: ula_op = ULA_ADD;
                    FUNCT_SUB: ula_op = ULA_SUB;
                    FUNCT_AND: ula_op = ULA_AND;
                    FUNCT_OR:  ula_op = ULA_OR;
                    FUNCT_SLT: ula_op = ULA_SLT;
                    default:   ula_op = ULA_ADD;
                endcase
            end
            default: ula_op = ULA_ADD;
        endcase
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Moore control unit for a multicycle MIPS-like datapath. One state register,
// outputs decoded from the state only, except the BRANCH pc_en which follows
// the zero flag in the same cycle. Write strobes are forced low while reset
// is held; the state register resets asynchronously to FETCH.
module controle_multiciclo
    import controle_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] ulaOp,
    output logic       ula_src_a,
    output logic [1:0] ula_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       iord,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [3:0] estado
);

    estado_t   state_q;
    estado_t   state_d;
    ula_tipo_t ula_tipo;
    logic      ula_ativa;
    logic [2:0] ula_op_dec;
    logic      pc_en_w;
    logic      ir_write_w;
    logic      mem_write_w;
    logic      reg_write_w;

    ula_controle u_ula_controle (
        .ula_tipo (ula_tipo),
        .funct    (funct),
        .ula_op   (ula_op_dec)
    );

    // State register; reset aborts any instruction and lands in FETCH at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state outputs; anything a state does not drive stays 0.
    always_comb begin
        state_d     = S_FETCH;
        ula_tipo    = TIPO_ADD;
        ula_ativa   = 1'b0;
        ula_src_a   = 1'b0;
        ula_src_b   = 2'b00;
        pc_src      = 2'b00;
        pc_en_w     = 1'b0;
        ir_write_w  = 1'b0;
        mem_write_w = 1'b0;
        reg_write_w = 1'b0;
        iord        = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ula_ativa  = 1'b1;
                ula_src_b  = 2'b01;
                ir_write_w = 1'b1;
                pc_en_w    = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed here while the opcode is decoded.
                ula_ativa = 1'b1;
                ula_src_b = 2'b11;
                if (is_mem_op(opcode))       state_d = S_MEMADR;
                else if (opcode == OP_RTYPE) state_d = S_EXEC;
                else if (opcode == OP_BEQ)   state_d = S_BRANCH;
                else if (opcode == OP_ADDI)  state_d = S_ADDIEX;
                else if (opcode == OP_J)     state_d = S_JUMP;
                else                         state_d = S_FETCH;
            end
            S_MEMADR: begin
                ula_ativa = 1'b1;
                ula_src_a = 1'b1;
                ula_src_b = 2'b10;
                if (opcode == OP_LW)      state_d = S_MEMRD;
                else if (opcode == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_FETCH;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg  = 1'b1;
                reg_write_w = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWR: begin
                iord        = 1'b1;
                mem_write_w = 1'b1;
                state_d     = S_FETCH;
            end
            S_EXEC: begin
                ula_ativa = 1'b1;
                ula_tipo  = TIPO_FUNCT;
                ula_src_a = 1'b1;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst     = 1'b1;
                reg_write_w = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                ula_ativa = 1'b1;
                ula_tipo  = TIPO_SUB;
                ula_src_a = 1'b1;
                pc_src    = 2'b01;
                pc_en_w   = zero;
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                ula_ativa = 1'b1;
                ula_src_a = 1'b1;
                ula_src_b = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_w = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pc_src  = 2'b10;
                pc_en_w = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // States that do not use the ULA present AND (000) rather than a stale code.
    assign ulaOp     = ula_ativa ? ula_op_dec : ULA_AND;

    // Strobes are held off for the whole time reset is asserted.
    assign pc_en     = pc_en_w     & rst;
    assign ir_write  = ir_write_w  & rst;
    assign mem_write = mem_write_w & rst;
    assign reg_write = reg_write_w & rst;

    assign estado    = state_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: walks each instruction class through
// its states and compares state code and the full output vector against
// hand-written expected values.
module tb_controle_multiciclo;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] ulaOp;
    logic       ula_src_a;
    logic [1:0] ula_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [3:0] estado;

    int checks;
    int failures;

    // Output vector: {ulaOp, src_a, src_b, pc_src, pc_en, ir_write, mem_write,
    //                 reg_write, iord, reg_dst, mem_to_reg}
    logic [14:0] obs;
    assign obs = {ulaOp, ula_src_a, ula_src_b, pc_src, pc_en, ir_write,
                  mem_write, reg_write, iord, reg_dst, mem_to_reg};

    localparam logic [14:0] V_RESET  = 15'b010_0_01_00_0_0_0_0_0_0_0;
    localparam logic [14:0] V_FETCH  = 15'b010_0_01_00_1_1_0_0_0_0_0;
    localparam logic [14:0] V_DECODE = 15'b010_0_11_00_0_0_0_0_0_0_0;
    localparam logic [14:0] V_MEMADR = 15'b010_1_10_00_0_0_0_0_0_0_0;
    localparam logic [14:0] V_MEMRD  = 15'b000_0_00_00_0_0_0_0_1_0_0;
    localparam logic [14:0] V_MEMWB  = 15'b000_0_00_00_0_0_0_1_0_0_1;
    localparam logic [14:0] V_MEMWR  = 15'b000_0_00_00_0_0_1_0_1_0_0;
    localparam logic [14:0] V_ALUWB  = 15'b000_0_00_00_0_0_0_1_0_1_0;
    localparam logic [14:0] V_BR_Z1  = 15'b110_1_00_01_1_0_0_0_0_0_0;
    localparam logic [14:0] V_BR_Z0  = 15'b110_1_00_01_0_0_0_0_0_0_0;
    localparam logic [14:0] V_ADDIWB = 15'b000_0_00_00_0_0_0_1_0_0_0;
    localparam logic [14:0] V_JUMP   = 15'b000_0_00_10_1_0_0_0_0_0_0;

    controle_multiciclo dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .ulaOp      (ulaOp),
        .ula_src_a  (ula_src_a),
        .ula_src_b  (ula_src_b),
        .pc_src     (pc_src),
        .pc_en      (pc_en),
        .ir_write   (ir_write),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .iord       (iord),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .estado     (estado)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Move to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Compare state code and full output vector in the current cycle.
    task automatic expect_state(input string tag, input logic [3:0] st, input logic [14:0] vec);
        #1;
        check({tag, "_estado"}, {28'd0, estado}, {28'd0, st});
        check({tag, "_out"}, {17'd0, obs}, {17'd0, vec});
    endtask

    logic [5:0] funct_tab [5];
    logic [2:0] op_tab    [5];

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        opcode   = 6'b000000;
        funct    = 6'b000000;
        zero     = 1'b0;
        funct_tab[0] = 6'b100010; op_tab[0] = 3'b110;
        funct_tab[1] = 6'b100100; op_tab[1] = 3'b000;
        funct_tab[2] = 6'b100101; op_tab[2] = 3'b001;
        funct_tab[3] = 6'b101010; op_tab[3] = 3'b111;
        funct_tab[4] = 6'b111111; op_tab[4] = 3'b010;

        // Reset: FETCH state, FETCH selects, strobes off, across clock edges.
        #2 rst = 1'b0;
        expect_state("reset", 4'd0, V_RESET);
        next_cycle();
        expect_state("reset_hold", 4'd0, V_RESET);
        #4 rst = 1'b1;

        // R-type add: 0,1,6,7,0.
        opcode = 6'b000000; funct = 6'b100000;
        expect_state("r_fetch", 4'd0, V_FETCH);
        next_cycle(); expect_state("r_decode", 4'd1, V_DECODE);
        next_cycle(); expect_state("r_exec", 4'd6, 15'b010_1_00_00_0_0_0_0_0_0_0);
        next_cycle();
        opcode = 6'b111111;
        expect_state("r_aluwb", 4'd7, V_ALUWB);
        next_cycle(); expect_state("r_back", 4'd0, V_FETCH);

        // lw: 0,1,2,3,4,0.
        opcode = 6'b100011;
        next_cycle(); expect_state("lw_decode", 4'd1, V_DECODE);
        next_cycle(); expect_state("lw_memadr", 4'd2, V_MEMADR);
        next_cycle(); expect_state("lw_memrd", 4'd3, V_MEMRD);
        next_cycle(); expect_state("lw_memwb", 4'd4, V_MEMWB);
        next_cycle(); expect_state("lw_back", 4'd0, V_FETCH);

        // beq taken, then not taken; pc_en follows zero within BRANCH.
        opcode = 6'b000100; zero = 1'b1;
        next_cycle(); expect_state("beq1_decode", 4'd1, V_DECODE);
        next_cycle(); expect_state("beq1_branch", 4'd8, V_BR_Z1);
        zero = 1'b0;
        #1 check("beq1_zero_drop", {31'd0, pc_en}, 32'd0);
        next_cycle(); expect_state("beq1_back", 4'd0, V_FETCH);
        next_cycle(); expect_state("beq2_decode", 4'd1, V_DECODE);
        next_cycle(); expect_state("beq2_branch", 4'd8, V_BR_Z0);
        next_cycle(); expect_state("beq2_back", 4'd0, V_FETCH);

        // R-type funct decode in EXEC.
        for (int i = 0; i < 5; i++) begin
            opcode = 6'b000000; funct = funct_tab[i];
            next_cycle(); expect_state("fn_decode", 4'd1, V_DECODE);
            next_cycle(); expect_state("fn_exec", 4'd6, {op_tab[i], 12'b1_00_00_0000000});
            next_cycle(); expect_state("fn_aluwb", 4'd7, V_ALUWB);
            next_cycle();
        end

        // addi: 0,1,9,10,0.
        opcode = 6'b001000;
        expect_state("addi_fetch", 4'd0, V_FETCH);
        next_cycle(); expect_state("addi_decode", 4'd1, V_DECODE);
        next_cycle(); expect_state("addi_ex", 4'd9, V_MEMADR);
        next_cycle(); expect_state("addi_wb", 4'd10, V_ADDIWB);
        next_cycle(); expect_state("addi_back", 4'd0, V_FETCH);

        // j: 0,1,11,0.
        opcode = 6'b000010;
        next_cycle(); expect_state("j_decode", 4'd1, V_DECODE);
        next_cycle(); expect_state("j_jump", 4'd11, V_JUMP);
        next_cycle(); expect_state("j_back", 4'd0, V_FETCH);

        // sw aborted by reset mid-cycle in MEMWR.
        opcode = 6'b101011;
        next_cycle(); expect_state("sw_decode", 4'd1, V_DECODE);
        next_cycle(); expect_state("sw_memadr", 4'd2, V_MEMADR);
        next_cycle(); expect_state("sw_memwr", 4'd5, V_MEMWR);
        #2 rst = 1'b0;
        expect_state("sw_abort", 4'd0, V_RESET);
        next_cycle(); expect_state("sw_abort_hold", 4'd0, V_RESET);
        opcode = 6'b111111;
        #3 rst = 1'b1;
        expect_state("rel_fetch", 4'd0, V_FETCH);

        // Unknown opcode: FETCH, DECODE, back to FETCH with no strobe in between.
        next_cycle(); expect_state("unk_decode", 4'd1, V_DECODE);
        next_cycle(); expect_state("unk_back", 4'd0, V_FETCH);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
